turn_sequencer: RTL and testbench

Sequences the robot's maneuvers from the 4-bit line-follower code produced by the direction-control stage. It turns that code into registered left/right motor commands and executes timed ninety-degree turns: overshoot, then pivot until the line is reacquired. It counts end-of-line STOP events as route legs, and toggles the `direction` signal fed back to the direction-control stage between legs. It sits between direction control and the motor drivers.

---
 rtl/team_fury_pkg.sv | 51 +++++
 rtl/maneuver_timer.sv | 30 +++
 rtl/turn_sequencer.sv | 271 +++++++++++++++++++++++++++
 tb/tb_turn_sequencer.sv | 347 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/team_fury_pkg.sv
// Shared definitions for the turn sequencer: direction codes, motor
// encodings, FSM state enum and the reverse-travel output helper.
// TURN_TIMEOUT_EN adds the FAULT state to the enum.
package team_fury_pkg;

    localparam int unsigned DIR_W   = 4;
    localparam int unsigned MOTOR_W = 2;

    // {turn[1:0], degree[1:0]} codes from the direction-control stage
    localparam logic [DIR_W-1:0] DIR_PROCEED      = 4'b0000;
    localparam logic [DIR_W-1:0] DIR_VEER_LEFT    = 4'b0101;
    localparam logic [DIR_W-1:0] DIR_HARD_LEFT    = 4'b0110;
    localparam logic [DIR_W-1:0] DIR_NINETY_LEFT  = 4'b0111;
    localparam logic [DIR_W-1:0] DIR_VEER_RIGHT   = 4'b1001;
    localparam logic [DIR_W-1:0] DIR_HARD_RIGHT   = 4'b1010;
    localparam logic [DIR_W-1:0] DIR_NINETY_RIGHT = 4'b1011;
    localparam logic [DIR_W-1:0] DIR_STOP         = 4'b1111;

    // Motor command {en, fwd}
    localparam logic [MOTOR_W-1:0] M_OFF = 2'b00;
    localparam logic [MOTOR_W-1:0] M_REV = 2'b10;
    localparam logic [MOTOR_W-1:0] M_FWD = 2'b11;

`ifdef TURN_TIMEOUT_EN
    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_FOLLOW    = 3'd1,
        ST_OVERSHOOT = 3'd2,
        ST_PIVOT     = 3'd3,
        ST_SETTLE    = 3'd4,
        ST_DONE      = 3'd5,
        ST_FAULT     = 3'd6
    } state_t;
`else
    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_FOLLOW    = 3'd1,
        ST_OVERSHOOT = 3'd2,
        ST_PIVOT     = 3'd3,
        ST_SETTLE    = 3'd4,
        ST_DONE      = 3'd5
    } state_t;
`endif

    // While travelling in reverse, an enabled motor has its fwd bit inverted
    function automatic logic [MOTOR_W-1:0] motor_drive(input logic [MOTOR_W-1:0] cmd,
                                                       input logic               forwards);
        motor_drive = (cmd[1] && !forwards) ? {1'b1, ~cmd[0]} : cmd;
    endfunction

endpackage

// File: rtl/maneuver_timer.sv
// Saturating cycle counter shared by the timed maneuver states.
// load clears the count; expire flags count == limit while enabled.
module maneuver_timer #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic             enable,
    input  logic [WIDTH-1:0] limit,
    output logic [WIDTH-1:0] count,
    output logic             expire
);

    localparam logic [WIDTH-1:0] COUNT_MAX = '1;

    // Count up while enabled, holding at all-ones instead of wrapping
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (load) begin
            count <= '0;
        end else if (enable && (count != COUNT_MAX)) begin
            count <= count + WIDTH'(1);
        end
    end

    assign expire = enable && (count == limit);

endmodule

// File: rtl/turn_sequencer.sv
// Turns line-follower direction codes into registered motor commands,
// runs timed ninety-degree turns (overshoot, then pivot until the line is
// reacquired) and counts STOP events as route legs.
// Optional macro TURN_TIMEOUT_EN: bounded pivot with a sticky fault.
module turn_sequencer
    import team_fury_pkg::*;
#(
    parameter int unsigned OVERSHOOT_CYCLES = 12_500_000,
    parameter int unsigned PIVOT_MIN_CYCLES = 6_250_000,
    parameter int unsigned PIVOT_MAX_CYCLES = 100_000_000,
    parameter int unsigned SETTLE_CYCLES    = 25_000_000,
    parameter int unsigned LEGS             = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               stop_req,
    input  logic [DIR_W-1:0]   dir_code,
    output logic               direction,
    output logic [MOTOR_W-1:0] motor_l,
    output logic [MOTOR_W-1:0] motor_r,
    output logic               busy,
    output logic               done,
    output logic               fault
);

    localparam int unsigned LEG_W = 4;

    // The pivot minimum is compared with >=, so the timer must be able to hold it
    localparam int unsigned SPAN_OS = (OVERSHOOT_CYCLES > SETTLE_CYCLES) ? OVERSHOOT_CYCLES
                                                                         : SETTLE_CYCLES;
    localparam int unsigned SPAN_PM = (SPAN_OS > PIVOT_MIN_CYCLES + 1) ? SPAN_OS
                                                                       : PIVOT_MIN_CYCLES + 1;
`ifdef TURN_TIMEOUT_EN
    localparam int unsigned SPAN_MAX = (SPAN_PM > PIVOT_MAX_CYCLES) ? SPAN_PM : PIVOT_MAX_CYCLES;
`else
    localparam int unsigned SPAN_MAX = SPAN_PM;
`endif
    localparam int unsigned TIMER_W = (SPAN_MAX > 1) ? $clog2(SPAN_MAX) : 1;

    localparam logic [TIMER_W-1:0] OVERSHOOT_LAST  = TIMER_W'(OVERSHOOT_CYCLES - 1);
    localparam logic [TIMER_W-1:0] SETTLE_LAST     = TIMER_W'(SETTLE_CYCLES - 1);
    localparam logic [TIMER_W-1:0] PIVOT_MIN_COUNT = TIMER_W'(PIVOT_MIN_CYCLES);
`ifdef TURN_TIMEOUT_EN
    localparam logic [TIMER_W-1:0] PIVOT_MAX_LAST  = TIMER_W'(PIVOT_MAX_CYCLES - 1);
`endif

    // Reject parameter sets the sequencer cannot honour
    if (LEGS < 1 || LEGS > 15 || OVERSHOOT_CYCLES < 1 || SETTLE_CYCLES < 1 ||
        PIVOT_MAX_CYCLES <= PIVOT_MIN_CYCLES) begin : g_bad_params
        $error("turn_sequencer: parameter out of range");
    end

    state_t             state;
    state_t             state_next;
    logic [LEG_W-1:0]   leg;
    logic [LEG_W-1:0]   leg_next;
    logic               side_right;
    logic               side_right_next;
    logic [MOTOR_W-1:0] cmd_l;
    logic [MOTOR_W-1:0] cmd_r;
    logic [MOTOR_W-1:0] cmd_l_next;
    logic [MOTOR_W-1:0] cmd_r_next;
    logic               dir_next;
    logic               done_next;
    logic               busy_next;
    logic               timer_load;
    logic               timer_enable;
    logic               timer_expire;
    logic [TIMER_W-1:0] timer_limit;
    logic [TIMER_W-1:0] timer_count;

    maneuver_timer #(
        .WIDTH (TIMER_W)
    ) u_timer (
        .clk    (clk),
        .rst_n  (rst_n),
        .load   (timer_load),
        .enable (timer_enable),
        .limit  (timer_limit),
        .count  (timer_count),
        .expire (timer_expire)
    );

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and next-output decode; commands are logical (forward frame)
    always_comb begin
        state_next      = state;
        leg_next        = leg;
        side_right_next = side_right;
        cmd_l_next      = cmd_l;
        cmd_r_next      = cmd_r;
        dir_next        = direction;
        done_next       = 1'b0;
        timer_enable    = 1'b0;
        timer_limit     = '0;

        if (stop_req) begin
            state_next = ST_IDLE;
            leg_next   = '0;
            dir_next   = 1'b1;
            cmd_l_next = M_OFF;
            cmd_r_next = M_OFF;
        end else begin
            case (state)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        state_next = ST_FOLLOW;
                        leg_next   = '0;
                        dir_next   = 1'b1;
                        cmd_l_next = M_OFF;
                        cmd_r_next = M_OFF;
                    end
                end
`ifdef TURN_TIMEOUT_EN
                ST_FAULT: begin
                    if (start) begin
                        state_next = ST_FOLLOW;
                        leg_next   = '0;
                        dir_next   = 1'b1;
                        cmd_l_next = M_OFF;
                        cmd_r_next = M_OFF;
                    end
                end
`endif
                ST_FOLLOW: begin
                    case (dir_code)
                        DIR_PROCEED: begin
                            cmd_l_next = M_FWD;
                            cmd_r_next = M_FWD;
                        end
                        DIR_VEER_LEFT: begin
                            cmd_l_next = M_OFF;
                            cmd_r_next = M_FWD;
                        end
                        DIR_HARD_LEFT: begin
                            cmd_l_next = M_REV;
                            cmd_r_next = M_FWD;
                        end
                        DIR_VEER_RIGHT: begin
                            cmd_l_next = M_FWD;
                            cmd_r_next = M_OFF;
                        end
                        DIR_HARD_RIGHT: begin
                            cmd_l_next = M_FWD;
                            cmd_r_next = M_REV;
                        end
                        DIR_NINETY_LEFT, DIR_NINETY_RIGHT: begin
                            side_right_next = (dir_code == DIR_NINETY_RIGHT);
                            state_next      = ST_OVERSHOOT;
                            cmd_l_next      = M_FWD;
                            cmd_r_next      = M_FWD;
                        end
                        DIR_STOP: begin
                            state_next = ST_SETTLE;
                            cmd_l_next = M_OFF;
                            cmd_r_next = M_OFF;
                        end
                        default: begin
                            // Unknown code: keep the previous command
                        end
                    endcase
                end
                ST_OVERSHOOT: begin
                    timer_enable = 1'b1;
                    timer_limit  = OVERSHOOT_LAST;
                    if (timer_expire) begin
                        state_next = ST_PIVOT;
                        cmd_l_next = side_right ? M_FWD : M_REV;
                        cmd_r_next = side_right ? M_REV : M_FWD;
                    end
                end
                ST_PIVOT: begin
                    timer_enable = 1'b1;
`ifdef TURN_TIMEOUT_EN
                    timer_limit  = PIVOT_MAX_LAST;
                    if (timer_expire) begin
                        state_next = ST_FAULT;
                        cmd_l_next = M_OFF;
                        cmd_r_next = M_OFF;
                    end else
`endif
                    if ((dir_code == DIR_PROCEED) && (timer_count >= PIVOT_MIN_COUNT)) begin
                        state_next = ST_FOLLOW;
                        cmd_l_next = M_FWD;
                        cmd_r_next = M_FWD;
                    end
                end
                ST_SETTLE: begin
                    timer_enable = 1'b1;
                    timer_limit  = SETTLE_LAST;
                    if (timer_expire) begin
                        leg_next = leg + LEG_W'(1);
                        if ((leg + LEG_W'(1)) == LEG_W'(LEGS)) begin
                            state_next = ST_DONE;
                            done_next  = 1'b1;
                        end else begin
                            state_next = ST_FOLLOW;
                            dir_next   = ~direction;
                        end
                    end
                end
                default: begin
                    state_next = ST_IDLE;
                    cmd_l_next = M_OFF;
                    cmd_r_next = M_OFF;
                end
            endcase
        end
    end

    // Every state change restarts the shared timer from zero
    assign timer_load = (state_next != state);

    assign busy_next = (state_next == ST_FOLLOW)    || (state_next == ST_OVERSHOOT) ||
                       (state_next == ST_PIVOT)     || (state_next == ST_SETTLE);

    // Output and datapath registers; reverse travel applied at the motor outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            leg        <= '0;
            side_right <= 1'b0;
            cmd_l      <= M_OFF;
            cmd_r      <= M_OFF;
            direction  <= 1'b1;
            motor_l    <= M_OFF;
            motor_r    <= M_OFF;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            leg        <= leg_next;
            side_right <= side_right_next;
            cmd_l      <= cmd_l_next;
            cmd_r      <= cmd_r_next;
            direction  <= dir_next;
            motor_l    <= motor_drive(cmd_l_next, dir_next);
            motor_r    <= motor_drive(cmd_r_next, dir_next);
            busy       <= busy_next;
            done       <= done_next;
        end
    end

`ifdef TURN_TIMEOUT_EN
    logic run_start;

    assign run_start = !stop_req && start &&
                       ((state == ST_IDLE) || (state == ST_DONE) || (state == ST_FAULT));

    // Fault sets on entering FAULT and survives stop_req until a run starts
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fault <= 1'b0;
        end else if (state_next == ST_FAULT) begin
            fault <= 1'b1;
        end else if (run_start) begin
            fault <= 1'b0;
        end
    end
`else
    assign fault = 1'b0;
`endif

endmodule

// File: tb/tb_turn_sequencer.sv
// Self-checking bench for turn_sequencer: decode table, hand-written
// maneuver sequences and randomized traffic against a behavioural model.
module tb_turn_sequencer;

    localparam int OV    = 4;
    localparam int PMIN  = 3;
    localparam int PMAX  = 20;
    localparam int SET   = 5;
    localparam int NLEGS = 2;

`ifdef TURN_TIMEOUT_EN
    localparam bit TIMEOUT_ON = 1'b1;
`else
    localparam bit TIMEOUT_ON = 1'b0;
`endif

    localparam int MD_IDLE   = 0;
    localparam int MD_FOLLOW = 1;
    localparam int MD_OVER   = 2;
    localparam int MD_PIVOT  = 3;
    localparam int MD_SETTLE = 4;
    localparam int MD_DONE   = 5;
    localparam int MD_FAULT  = 6;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic       stop_req;
    logic [3:0] dir_code;
    logic       direction;
    logic [1:0] motor_l;
    logic [1:0] motor_r;
    logic       busy;
    logic       done;
    logic       fault;

    int n_checks = 0;
    int n_errors = 0;

    // Behavioural model state
    int         m_mode;
    int         m_t;
    int         m_leg;
    bit         m_dir;
    bit         m_right;
    bit         m_done;
    bit         m_fault;
    logic [1:0] m_l;
    logic [1:0] m_r;

    always #5 clk = ~clk;

    turn_sequencer #(
        .OVERSHOOT_CYCLES (OV),
        .PIVOT_MIN_CYCLES (PMIN),
        .PIVOT_MAX_CYCLES (PMAX),
        .SETTLE_CYCLES    (SET),
        .LEGS             (NLEGS)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .stop_req  (stop_req),
        .dir_code  (dir_code),
        .direction (direction),
        .motor_l   (motor_l),
        .motor_r   (motor_r),
        .busy      (busy),
        .done      (done),
        .fault     (fault)
    );

    task automatic check(input string name, input logic [1:0] act, input logic [1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    // What the motor pins show for a forward-frame command
    function automatic logic [1:0] shown(input logic [1:0] c, input bit fwd);
        if (c[1] && !fwd) return c ^ 2'b01;
        return c;
    endfunction

    task automatic model_reset();
        m_mode  = MD_IDLE;
        m_t     = 0;
        m_leg   = 0;
        m_dir   = 1'b1;
        m_right = 1'b0;
        m_done  = 1'b0;
        m_fault = 1'b0;
        m_l     = 2'b00;
        m_r     = 2'b00;
    endtask

    // One clock edge of the route rules
    task automatic model_step(input bit s, input bit sr, input logic [3:0] c);
        m_done = 1'b0;
        if (sr) begin
            m_mode = MD_IDLE; m_leg = 0; m_dir = 1'b1; m_t = 0;
            m_l = 2'b00; m_r = 2'b00;
        end else begin
            case (m_mode)
                MD_IDLE, MD_DONE, MD_FAULT: begin
                    if (s) begin
                        m_mode = MD_FOLLOW; m_leg = 0; m_dir = 1'b1; m_fault = 1'b0;
                        m_l = 2'b00; m_r = 2'b00;
                    end
                end
                MD_FOLLOW: begin
                    case (c)
                        4'b0000: begin m_l = 2'b11; m_r = 2'b11; end
                        4'b0101: begin m_l = 2'b00; m_r = 2'b11; end
                        4'b0110: begin m_l = 2'b10; m_r = 2'b11; end
                        4'b1001: begin m_l = 2'b11; m_r = 2'b00; end
                        4'b1010: begin m_l = 2'b11; m_r = 2'b10; end
                        4'b0111, 4'b1011: begin
                            m_right = (c == 4'b1011); m_mode = MD_OVER; m_t = 0;
                            m_l = 2'b11; m_r = 2'b11;
                        end
                        4'b1111: begin
                            m_mode = MD_SETTLE; m_t = 0; m_l = 2'b00; m_r = 2'b00;
                        end
                        default: ;
                    endcase
                end
                MD_OVER: begin
                    if (m_t == OV - 1) begin
                        m_mode = MD_PIVOT; m_t = 0;
                        m_l = m_right ? 2'b11 : 2'b10;
                        m_r = m_right ? 2'b10 : 2'b11;
                    end else m_t++;
                end
                MD_PIVOT: begin
                    if (TIMEOUT_ON && m_t == PMAX - 1) begin
                        m_mode = MD_FAULT; m_fault = 1'b1; m_l = 2'b00; m_r = 2'b00;
                    end else if (c == 4'b0000 && m_t >= PMIN) begin
                        m_mode = MD_FOLLOW; m_l = 2'b11; m_r = 2'b11;
                    end else m_t++;
                end
                MD_SETTLE: begin
                    if (m_t == SET - 1) begin
                        m_leg++;
                        if (m_leg == NLEGS) begin
                            m_mode = MD_DONE; m_done = 1'b1;
                        end else begin
                            m_dir = !m_dir; m_mode = MD_FOLLOW;
                        end
                    end else m_t++;
                end
                default: ;
            endcase
        end
    endtask

    task automatic check_all();
        bit exp_busy;
        exp_busy = (m_mode == MD_FOLLOW) || (m_mode == MD_OVER) ||
                   (m_mode == MD_PIVOT)  || (m_mode == MD_SETTLE);
        check("direction", 2'(direction), 2'(m_dir));
        check("motor_l",   motor_l,       shown(m_l, m_dir));
        check("motor_r",   motor_r,       shown(m_r, m_dir));
        check("busy",      2'(busy),      2'(exp_busy));
        check("done",      2'(done),      2'(m_done));
        check("fault",     2'(fault),     2'(m_fault));
    endtask

    task automatic step(input bit s, input bit sr, input logic [3:0] c);
        @(negedge clk);
        start = s; stop_req = sr; dir_code = c;
        @(posedge clk);
        model_step(s, sr, c);
        #1;
        check_all();
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0; start = 1'b0; stop_req = 1'b0; dir_code = 4'b0000;
        repeat (2) @(posedge clk);
        model_reset();
        #1;
        check_all();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    typedef struct {
        logic [3:0] code;
        logic [1:0] l;
        logic [1:0] r;
    } vec_t;

    vec_t vecs[12];
    logic [3:0] pool[13];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: bench did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0]  = '{4'b0000, 2'b11, 2'b11};
        vecs[1]  = '{4'b0001, 2'b11, 2'b11};
        vecs[2]  = '{4'b0101, 2'b00, 2'b11};
        vecs[3]  = '{4'b0100, 2'b00, 2'b11};
        vecs[4]  = '{4'b0110, 2'b10, 2'b11};
        vecs[5]  = '{4'b1001, 2'b11, 2'b00};
        vecs[6]  = '{4'b1000, 2'b11, 2'b00};
        vecs[7]  = '{4'b1010, 2'b11, 2'b10};
        vecs[8]  = '{4'b1100, 2'b11, 2'b10};
        vecs[9]  = '{4'b1110, 2'b11, 2'b10};
        vecs[10] = '{4'b0011, 2'b11, 2'b10};
        vecs[11] = '{4'b1101, 2'b11, 2'b10};

        pool = '{4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0101, 4'b0110, 4'b0111,
                 4'b1001, 4'b1010, 4'b1011, 4'b1111, 4'b0010, 4'b1101};

        rst_n = 1'b0; start = 1'b0; stop_req = 1'b0; dir_code = 4'b0000;
        model_reset();

        // Reset state
        do_reset();
        check("rst_dir",  2'(direction), 2'b01);
        check("rst_ml",   motor_l,       2'b00);
        check("rst_busy", 2'(busy),      2'b00);

        // FOLLOW decode table, undefined codes hold
        step(1'b1, 1'b0, 4'b0000);
        for (int i = 0; i < 12; i++) begin
            step(1'b0, 1'b0, vecs[i].code);
            check("tbl_l", motor_l, vecs[i].l);
            check("tbl_r", motor_r, vecs[i].r);
        end

        // Main route: veer, ninety right, pivot, two legs
        do_reset();
        step(1'b1, 1'b0, 4'b0000);
        check("start_busy", 2'(busy), 2'b01);
        step(1'b0, 1'b0, 4'b0101);
        check("veer_l", motor_l, 2'b00);
        check("veer_r", motor_r, 2'b11);
        step(1'b0, 1'b0, 4'b1011);
        check("os_l", motor_l, 2'b11);
        for (int i = 0; i < OV - 1; i++) begin
            step(1'b0, 1'b0, 4'b1011);
            check("os_r", motor_r, 2'b11);
        end
        step(1'b0, 1'b0, 4'b1011);
        check("piv_l", motor_l, 2'b11);
        check("piv_r", motor_r, 2'b10);
        step(1'b0, 1'b0, 4'b1011);
        step(1'b0, 1'b0, 4'b0000);
        check("early_proceed_r", motor_r, 2'b10);
        step(1'b0, 1'b0, 4'b1011);
        step(1'b0, 1'b0, 4'b0000);
        check("reacq_l", motor_l, 2'b11);
        check("reacq_r", motor_r, 2'b11);
        for (int i = 0; i < SET; i++) begin
            step(1'b0, 1'b0, 4'b1111);
            check("settle_l", motor_l, 2'b00);
        end
        step(1'b0, 1'b0, 4'b1111);
        check("leg_dir", 2'(direction), 2'b00);
        step(1'b0, 1'b0, 4'b0000);
        check("rev_l", motor_l, 2'b10);
        check("rev_r", motor_r, 2'b10);
        for (int i = 0; i < SET; i++) begin
            step(1'b0, 1'b0, 4'b1111);
            check("settle2_done", 2'(done), 2'b00);
        end
        step(1'b0, 1'b0, 4'b0000);
        check("done_pulse", 2'(done), 2'b01);
        check("done_busy",  2'(busy), 2'b00);
        step(1'b0, 1'b0, 4'b0000);
        check("done_low", 2'(done), 2'b00);

        // stop_req during reverse overshoot, same edge as a NINETY code
        do_reset();
        step(1'b1, 1'b0, 4'b0000);
        step(1'b0, 1'b0, 4'b1111);
        for (int i = 0; i < SET; i++) step(1'b0, 1'b0, 4'b1111);
        step(1'b0, 1'b0, 4'b0111);
        step(1'b0, 1'b1, 4'b0111);
        check("abort_dir",  2'(direction), 2'b01);
        check("abort_ml",   motor_l,       2'b00);
        check("abort_busy", 2'(busy),      2'b00);

        // Pivot without reacquire, then asynchronous reset mid-pivot
        do_reset();
        step(1'b1, 1'b0, 4'b0000);
        step(1'b0, 1'b0, 4'b0111);
        for (int i = 0; i < OV; i++) step(1'b0, 1'b0, 4'b0111);
        check("lpiv_l", motor_l, 2'b10);
        check("lpiv_r", motor_r, 2'b11);
`ifdef TURN_TIMEOUT_EN
        for (int i = 0; i < PMAX - 1; i++) step(1'b0, 1'b0, 4'b0111);
        check("pre_fault", 2'(fault), 2'b00);
        step(1'b0, 1'b0, 4'b0111);
        check("fault_set",  2'(fault), 2'b01);
        check("fault_busy", 2'(busy),  2'b00);
        check("fault_ml",   motor_l,   2'b00);
        step(1'b0, 1'b1, 4'b0000);
        check("fault_sticky", 2'(fault), 2'b01);
        step(1'b1, 1'b0, 4'b0000);
        check("fault_clr", 2'(fault), 2'b00);
        step(1'b0, 1'b0, 4'b0111);
        for (int i = 0; i < OV + 2; i++) step(1'b0, 1'b0, 4'b0111);
`else
        for (int i = 0; i < 100; i++) step(1'b0, 1'b0, 4'b0111);
        check("long_piv_l", motor_l,   2'b10);
        check("long_fault", 2'(fault), 2'b00);
        check("long_busy",  2'(busy),  2'b01);
        step(1'b0, 1'b0, 4'b0000);
        check("sat_reacq_l", motor_l, 2'b11);
        step(1'b0, 1'b0, 4'b1011);
        for (int i = 0; i < OV + 1; i++) step(1'b0, 1'b0, 4'b1011);
`endif
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_dir",  2'(direction), 2'b01);
        check("arst_ml",   motor_l,       2'b00);
        check("arst_mr",   motor_r,       2'b00);
        check("arst_busy", 2'(busy),      2'b00);
        check("arst_done", 2'(done),      2'b00);
        check("arst_flt",  2'(fault),     2'b00);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;

        // Randomized traffic against the model
        for (int i = 0; i < 3000; i++) begin
            step(($urandom_range(0, 15) == 0), ($urandom_range(0, 79) == 0),
                 pool[$urandom_range(0, 12)]);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
